// File: rtl/sram_ctrl.sv
// sram_ctrl: valid/ready front end for an asynchronous 16-bit SRAM.
// Each access runs setup, a WAIT-cycle strobe and hold, then pulses rsp_valid.
module sram_ctrl #(
   parameter int AW   = 16,
   parameter int DW   = 16,
   parameter int WAIT = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [1:0]    req_be,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          rsp_valid,
   output logic [DW-1:0] rsp_rdata,
   output logic          sram_ce_n,
   output logic          sram_oe_n,
   output logic          sram_we_n,
   output logic          sram_lb_n,
   output logic          sram_ub_n,
   output logic [AW-1:0] sram_addr,
   output logic [DW-1:0] sram_din,
   input  logic [DW-1:0] sram_dout
);

   localparam int BW = DW / 2;

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [3:0]    cnt;
   logic          we_q;
   logic [1:0]    be_q;
   logic          accept;
   logic          cur_we;
   logic [1:0]    cur_be;
   logic          ce_nxt;
   logic          oe_nxt;
   logic          we_nxt;
   logic          lb_nxt;
   logic          ub_nxt;
   logic          rsp_nxt;
   logic [DW-1:0] rd_mask;

   assign req_ready = (state == IDLE);
   assign accept    = req_valid && req_ready;

   // Strobes are registered from the next state, so the accepting
   // edge must see the incoming request rather than the captured one.
   assign cur_we = req_ready ? req_we : we_q;
   assign cur_be = req_ready ? req_be : be_q;

   assign rd_mask = {be_q[1] ? sram_dout[DW-1:BW] : {BW{1'b0}},
                     be_q[0] ? sram_dout[BW-1:0]  : {BW{1'b0}}};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SETUP;
         SETUP:   state_nxt = STROBE;
         STROBE:  if (cnt == 4'd0) state_nxt = HOLD;
         HOLD:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ce_nxt  = 1'b1;
      oe_nxt  = 1'b1;
      we_nxt  = 1'b1;
      lb_nxt  = 1'b1;
      ub_nxt  = 1'b1;
      rsp_nxt = 1'b0;
      if (state_nxt != IDLE) begin
         ce_nxt = 1'b0;
         lb_nxt = ~cur_be[0];
         ub_nxt = ~cur_be[1];
      end
      if (state_nxt == STROBE) begin
         we_nxt = ~cur_we;
         oe_nxt = cur_we;
      end
      if (state_nxt == HOLD) rsp_nxt = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sram_ce_n <= 1'b1;
         sram_oe_n <= 1'b1;
         sram_we_n <= 1'b1;
         sram_lb_n <= 1'b1;
         sram_ub_n <= 1'b1;
         sram_addr <= '0;
         sram_din  <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         we_q      <= 1'b0;
         be_q      <= 2'b00;
         cnt       <= 4'd0;
      end else begin
         sram_ce_n <= ce_nxt;
         sram_oe_n <= oe_nxt;
         sram_we_n <= we_nxt;
         sram_lb_n <= lb_nxt;
         sram_ub_n <= ub_nxt;
         rsp_valid <= rsp_nxt;
         rsp_rdata <= (rsp_nxt && !we_q) ? rd_mask : '0;
         if (accept) begin
            we_q      <= req_we;
            be_q      <= req_be;
            sram_addr <= req_addr;
            sram_din  <= req_wdata;
         end
         if (state == SETUP)
            cnt <= 4'(WAIT - 1);
         else if (state == STROBE && cnt != 4'd0)
            cnt <= cnt - 4'd1;
      end
   end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed vectors against two controllers (WAIT=2 and
// WAIT=1), each wired to a behavioural SRAM with byte-lane writes.
module tb_sram_ctrl;

   localparam int W0 = 2;
   localparam int W1 = 1;

   logic        clk;
   logic        rst;
   logic [1:0]  valid;
   logic [1:0]  ready;
   logic        req_we;
   logic [1:0]  req_be;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic [1:0]  rsp_v;
   logic [1:0]  ce_n, oe_n, we_n, lb_n, ub_n;
   logic [15:0] rdata  [2];
   logic [15:0] addr_o [2];
   logic [15:0] din    [2];
   logic [15:0] dout   [2];
   logic [15:0] mem0   [0:65535];
   logic [15:0] mem1   [0:65535];

   int checks = 0;
   int failures = 0;

   int n_ce[2], n_we[2], n_oe[2], n_lb[2], n_ub[2];
   int n_rsp[2], n_excl[2], n_stab[2];
   bit pce[2];
   logic [15:0] pa[2], pd[2];

   typedef struct {
      int         d;
      bit         we;
      bit [1:0]   be;
      bit [15:0]  a;
      bit [15:0]  wd;
      bit [15:0]  exp;
   } vec_t;

   typedef struct {
      bit [15:0] rd;
      int lat, nce, nwe, noe, nlb, nub, nrsp, wt;
   } meas_t;

   sram_ctrl #(.AW(16), .DW(16), .WAIT(W0)) dut0 (
      .clk(clk), .rst(rst),
      .req_valid(valid[0]), .req_ready(ready[0]),
      .req_we(req_we), .req_be(req_be),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_v[0]), .rsp_rdata(rdata[0]),
      .sram_ce_n(ce_n[0]), .sram_oe_n(oe_n[0]), .sram_we_n(we_n[0]),
      .sram_lb_n(lb_n[0]), .sram_ub_n(ub_n[0]),
      .sram_addr(addr_o[0]), .sram_din(din[0]), .sram_dout(dout[0])
   );

   sram_ctrl #(.AW(16), .DW(16), .WAIT(W1)) dut1 (
      .clk(clk), .rst(rst),
      .req_valid(valid[1]), .req_ready(ready[1]),
      .req_we(req_we), .req_be(req_be),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_v[1]), .rsp_rdata(rdata[1]),
      .sram_ce_n(ce_n[1]), .sram_oe_n(oe_n[1]), .sram_we_n(we_n[1]),
      .sram_lb_n(lb_n[1]), .sram_ub_n(ub_n[1]),
      .sram_addr(addr_o[1]), .sram_din(din[1]), .sram_dout(dout[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign dout[0] = (!ce_n[0] && !oe_n[0]) ? mem0[addr_o[0]] : 16'hDEAD;
   assign dout[1] = (!ce_n[1] && !oe_n[1]) ? mem1[addr_o[1]] : 16'hDEAD;

   always @(posedge clk) begin
      if (!ce_n[0] && !we_n[0]) begin
         if (!lb_n[0]) mem0[addr_o[0]][7:0]  <= din[0][7:0];
         if (!ub_n[0]) mem0[addr_o[0]][15:8] <= din[0][15:8];
      end
      if (!ce_n[1] && !we_n[1]) begin
         if (!lb_n[1]) mem1[addr_o[1]][7:0]  <= din[1][7:0];
         if (!ub_n[1]) mem1[addr_o[1]][15:8] <= din[1][15:8];
      end
   end

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!ce_n[d]) n_ce[d]++;
         if (!we_n[d]) n_we[d]++;
         if (!oe_n[d]) n_oe[d]++;
         if (!we_n[d] || !oe_n[d]) begin
            if (!lb_n[d]) n_lb[d]++;
            if (!ub_n[d]) n_ub[d]++;
         end
         if (!we_n[d] && !oe_n[d]) n_excl[d]++;
         if (!ce_n[d] && pce[d] && (addr_o[d] != pa[d] || din[d] != pd[d]))
            n_stab[d]++;
         pce[d] = !ce_n[d];
         pa[d]  = addr_o[d];
         pd[d]  = din[d];
         if (rsp_v[d]) n_rsp[d]++;
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                  nm, act, act, exp, exp);
      end
   endtask

   task automatic run(input int d, input bit we, input bit [1:0] be,
                      input bit [15:0] a, input bit [15:0] wd,
                      output meas_t m);
      int s_ce, s_we, s_oe, s_lb, s_ub, s_rsp, j;
      @(negedge clk);
      req_we = we; req_be = be; req_addr = a; req_wdata = wd;
      valid[d] = 1'b1;
      m.wt = 0;
      while (!ready[d] && m.wt < 20) begin
         @(negedge clk);
         m.wt++;
      end
      s_ce = n_ce[d]; s_we = n_we[d]; s_oe = n_oe[d];
      s_lb = n_lb[d]; s_ub = n_ub[d]; s_rsp = n_rsp[d];
      @(negedge clk);
      valid[d] = 1'b0;
      m.lat = -1;
      m.rd  = 16'h0;
      j = 0;
      while (m.lat < 0 && j < 40) begin
         if (rsp_v[d]) begin
            m.lat = j;
            m.rd  = rdata[d];
         end else begin
            @(negedge clk);
            j++;
         end
      end
      repeat (2) @(negedge clk);
      m.nce = n_ce[d] - s_ce; m.nwe = n_we[d] - s_we;
      m.noe = n_oe[d] - s_oe; m.nlb = n_lb[d] - s_lb;
      m.nub = n_ub[d] - s_ub; m.nrsp = n_rsp[d] - s_rsp;
   endtask

   task automatic check(input string tag, input int d, input bit we,
                        input bit [1:0] be, input bit [15:0] exp,
                        input meas_t m);
      int w;
      w = (d == 0) ? W0 : W1;
      chk({tag, " rdata"}, int'(m.rd), int'(exp));
      chk({tag, " latency"}, m.lat, w + 1);
      chk({tag, " ce_n low"}, m.nce, w + 2);
      chk({tag, " we_n low"}, m.nwe, we ? w : 0);
      chk({tag, " oe_n low"}, m.noe, we ? 0 : w);
      chk({tag, " lb_n low"}, m.nlb, be[0] ? w : 0);
      chk({tag, " ub_n low"}, m.nub, be[1] ? w : 0);
      chk({tag, " rsp pulses"}, m.nrsp, 1);
   endtask

   vec_t  tbl[11];
   meas_t m;
   int    t1, t2, nlow, ce_gap, sp;

   initial begin
      tbl[0]  = '{0, 1'b1, 2'b11, 16'd1234, 16'h04D2, 16'h0000};
      tbl[1]  = '{0, 1'b0, 2'b11, 16'd1234, 16'h0000, 16'h04D2};
      tbl[2]  = '{0, 1'b1, 2'b11, 16'd5678, 16'hFFFF, 16'h0000};
      tbl[3]  = '{0, 1'b1, 2'b01, 16'd5678, 16'h0000, 16'h0000};
      tbl[4]  = '{0, 1'b0, 2'b11, 16'd5678, 16'h0000, 16'hFF00};
      tbl[5]  = '{0, 1'b0, 2'b10, 16'd5678, 16'h0000, 16'hFF00};
      tbl[6]  = '{0, 1'b0, 2'b01, 16'd5678, 16'h0000, 16'h0000};
      tbl[7]  = '{1, 1'b1, 2'b11, 16'd0,    16'hA55A, 16'h0000};
      tbl[8]  = '{1, 1'b0, 2'b11, 16'd0,    16'h0000, 16'hA55A};
      tbl[9]  = '{1, 1'b1, 2'b00, 16'd0,    16'hBEEF, 16'h0000};
      tbl[10] = '{1, 1'b0, 2'b11, 16'd0,    16'h0000, 16'hA55A};

      rst = 1'b0;
      valid = 2'b00;
      req_we = 1'b0; req_be = 2'b00; req_addr = '0; req_wdata = '0;

      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("reset d%0d ready", d), int'(ready[d]), 1);
         chk($sformatf("reset d%0d rsp_valid", d), int'(rsp_v[d]), 0);
         chk($sformatf("reset d%0d rsp_rdata", d), int'(rdata[d]), 0);
         chk($sformatf("reset d%0d strobes", d),
             int'({ce_n[d], oe_n[d], we_n[d], lb_n[d], ub_n[d]}), 31);
         chk($sformatf("reset d%0d addr", d), int'(addr_o[d]), 0);
         chk($sformatf("reset d%0d din", d), int'(din[d]), 0);
      end
      rst = 1'b1;

      for (int i = 0; i < 11; i++) begin
         run(tbl[i].d, tbl[i].we, tbl[i].be, tbl[i].a, tbl[i].wd, m);
         check($sformatf("vec%0d", i), tbl[i].d, tbl[i].we, tbl[i].be,
               tbl[i].exp, m);
      end

      // Back-to-back writes with req_valid held high throughout.
      @(negedge clk);
      req_we = 1'b1; req_be = 2'b11; req_addr = 16'd0; req_wdata = 16'h1111;
      valid[0] = 1'b1;
      t1 = -1; t2 = -1; nlow = 0; ce_gap = 0;
      for (int i = 0; i < 30 && t2 < 0; i++) begin
         if (t1 >= 0 && i == t1 + 1) begin
            req_addr = 16'd10;
            req_wdata = 16'h2222;
         end
         if (ready[0]) begin
            if (t1 < 0) t1 = i;
            else begin
               t2 = i;
               ce_gap = int'(ce_n[0]);
            end
         end else if (t1 >= 0) nlow++;
         @(negedge clk);
      end
      valid[0] = 1'b0;
      chk("b2b accept spacing", t2 - t1, W0 + 3);
      chk("b2b ready low", nlow, W0 + 2);
      chk("b2b ce_n idle gap", ce_gap, 1);
      repeat (8) @(negedge clk);
      run(0, 1'b0, 2'b11, 16'd0, 16'h0, m);
      check("b2b rd0", 0, 1'b0, 2'b11, 16'h1111, m);
      run(0, 1'b0, 2'b11, 16'd10, 16'h0, m);
      check("b2b rd10", 0, 1'b0, 2'b11, 16'h2222, m);

      // Reset during the strobe phase of a write.
      @(negedge clk);
      req_we = 1'b1; req_be = 2'b11; req_addr = 16'd10; req_wdata = 16'h3333;
      valid[0] = 1'b1;
      @(negedge clk);
      valid[0] = 1'b0;
      chk("midrst setup ce_n", int'(ce_n[0]), 0);
      @(negedge clk);
      chk("midrst strobe we_n", int'(we_n[0]), 0);
      sp = n_rsp[0];
      #2 rst = 1'b0;
      #1;
      chk("midrst strobes", int'({ce_n[0], oe_n[0], we_n[0], lb_n[0], ub_n[0]}), 31);
      chk("midrst rsp_valid", int'(rsp_v[0]), 0);
      chk("midrst ready", int'(ready[0]), 1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (6) @(negedge clk);
      chk("midrst no rsp", n_rsp[0] - sp, 0);
      chk("midrst ready after", int'(ready[0]), 1);
      run(0, 1'b0, 2'b11, 16'd0, 16'h0, m);
      chk("midrst first-edge accept", m.wt, 0);
      check("midrst rd0", 0, 1'b0, 2'b11, 16'h1111, m);

      for (int d = 0; d < 2; d++) begin
         chk($sformatf("d%0d we/oe both low", d), n_excl[d], 0);
         chk($sformatf("d%0d addr/din unstable", d), n_stab[d], 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Synchronous controller between the processor data path and the asynchronous 16-bit SRAM (`sram`: active-low CE/OE/WE/LB/UB, 16-bit addr, din, dout). It accepts one read or write request at a time over a valid/ready handshake and sequences the SRAM control strobes through setup, strobe and hold phases. The strobe phase is a programmable number of clock cycles. It returns read data, or a write completion, as a one-cycle response pulse.

## Interface
- `AW`, 16, address width
- `DW`, 16, data width; fixed at 2 byte lanes
- `WAIT`, 2, strobe-phase length in clocks; legal range 1..15, 0 is illegal
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `req_valid`  in  1  request present
- `req_ready`  out  1  controller can accept a request (high only in IDLE)
- `req_we`  in  1  1 = write, 0 = read
- `req_be`  in  2  byte enables; bit0 = low byte (LB), bit1 = high byte (UB)
- `req_addr`  in  AW  word address
- `req_wdata`  in  DW  write data
- `rsp_valid`  out  1  one-cycle completion pulse
- `rsp_rdata`  out  DW  read data, valid with `rsp_valid`
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`, `sram_lb_n`, `sram_ub_n`  out  1 each  SRAM strobes, all active-low
- `sram_addr`  out  AW  SRAM address
- `sram_din`  out  DW  SRAM write data
- `sram_dout`  in  DW  SRAM read data

## Operation
- **State machine:** IDLE → SETUP → STROBE → HOLD → IDLE.
- **IDLE**
  - `req_ready`=1.
  - All strobes high.
  - On `req_valid && req_ready`, register we, be, addr, wdata, then go to SETUP.
- **SETUP (1 cycle)**
  - `sram_ce_n`=0.
  - `sram_addr` and `sram_din` driven from the captured request.
  - `lb_n`=~be[0], `ub_n`=~be[1].
  - `we_n`=1, `oe_n`=1.
- **STROBE (WAIT cycles)**
  - Same drive as SETUP, plus `we_n`=0 for a write or `oe_n`=0 for a read.
  - A 4-bit down-counter loads WAIT-1 on entry and leaves the state when it reaches 0.
  - Read only: `sram_dout` is registered on the last STROBE cycle, with each disabled byte lane forced to 0x00.
- **HOLD (1 cycle)**
  - `we_n`=1 and `oe_n`=1.
  - `ce_n`, `lb_n`, `ub_n`, addr and din remain held.
  - `rsp_valid`=1.
  - `rsp_rdata` = captured read data for a read, 0x0000 for a write.
- **be=2'b00:** runs the full sequence with `lb_n`=`ub_n`=1. No memory change; the response returns rdata 0x0000.
- **Output timing:** all SRAM outputs are registered, so no glitches on the strobes.
- **Strobe exclusivity:** `we_n` and `oe_n` are never both 0.
- **addr/din stability:** both are stable for the whole period `ce_n`=0.
- **Requests while busy:** `req_*` is ignored outside IDLE. Upstream holds the request until the handshake completes.

## Timing
- **Reset values** (asserted asynchronously, held while `rst`=0):
  - State IDLE, `req_ready`=1.
  - `rsp_valid`=0, `rsp_rdata`=0.
  - All `sram_*_n`=1.
  - `sram_addr`=0, `sram_din`=0.
- **Per-request timing,** with the request accepted at edge k:
  - `ce_n` falls after k.
  - The strobe is low for exactly WAIT cycles, starting at k+1.
  - `rsp_valid` is high during cycle k+WAIT+1 (sampled at edge k+WAIT+2).
  - `req_ready` returns high after that edge.
- **Throughput:** one access per WAIT+3 cycles. `ce_n` is low WAIT+2 cycles per access.
- **No bypass:** `req_ready` is high only in IDLE.
- **Reset mid-operation:** all strobes go high immediately. The transaction is dropped with no response. After release the controller accepts on the first edge with `req_valid`.

## Test plan
- **Word write then read** (bench with a behavioural SRAM model, WAIT=2):
  - Write 0x04D2 to addr 1234, be=11 → `we_n` low exactly 2 cycles; `ce_n` low 4 cycles; `oe_n` stays 1; rsp at k+3.
  - Read addr 1234 → `rsp_rdata`=0x04D2 with `rsp_valid` at k+3.
- **Byte lanes:**
  - Write 0xFFFF to 5678 (be=11), then 0x0000 with be=01 → `lb_n`=0 and `ub_n`=1 during strobe.
  - Read be=11 → 0xFF00.
  - Read be=10 → 0xFF00; read be=01 → 0x0000.
- **Back-to-back:** hold `req_valid`=1 for writes to addr 0 and 10 → `req_ready` low for 4 cycles between accepts; accepts spaced 5 cycles; `ce_n` returns to 1 for the IDLE cycle between accesses.
- **Reset mid-operation:** assert `rst`=0 during STROBE of a write to addr 10 → all strobes 1 immediately, `rsp_valid` never pulses, `req_ready`=1 after release.
- **WAIT=1 build:** read at addr 0 → `oe_n` low 1 cycle, rsp at k+2. Separately, be=00 write → no SRAM change, rdata 0x0000.
